// File: rtl/bcd_addsub_seq_pkg.sv
// ----------------------------------------------------------------------------
// | Module   : bcd_addsub_seq_pkg                                            |
// | Purpose  : Shared constants, state encoding and digit helper for the     |
// |            sequential packed-BCD adder/subtractor.                       |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// ----------------------------------------------------------------------------
`default_nettype none

package bcd_addsub_seq_pkg;

  localparam logic       OP_ADD    = 1'b0;
  localparam logic       OP_SUB    = 1'b1;
  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam int         BCD_RADIX = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // A nibble is a legal BCD digit only in the range 0..9.
  function automatic logic digit_bad(input logic [3:0] d);
    return d > BCD_MAX;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_addsub_seq_digit_alu.sv
// ----------------------------------------------------------------------------
// | Module   : bcd_addsub_seq_digit_alu                                      |
// | Purpose  : Combinational single-digit BCD add/subtract with carry or     |
// |            borrow, time-multiplexed across digits by the top level.      |
// | Ports    : a, b   in  4  operand digits                                  |
// |            cin    in  1  carry (add) or borrow (sub) in                  |
// |            op     in  1  0 = add, 1 = subtract                           |
// |            digit  out 4  result digit                                    |
// |            cout   out 1  carry (add) or borrow (sub) out                 |
// | Revision : 1.0  initial release                                          |
// ----------------------------------------------------------------------------
`default_nettype none

module bcd_addsub_seq_digit_alu
  import bcd_addsub_seq_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       op,
  output logic [3:0] digit,
  output logic       cout
);

  localparam logic [3:0] RADIX4 = 4'(BCD_RADIX);

  logic [4:0]        sum;
  logic signed [5:0] diff;

  always_comb begin
    sum   = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    diff  = $signed({2'b00, a}) - $signed({2'b00, b}) - $signed({5'b00000, cin});
    digit = sum[3:0];
    cout  = 1'b0;
    if (op == OP_SUB) begin
      // Low nibble arithmetic is mod 16, so +10 on the low bits equals (d+10)[3:0].
      if (diff < 0) begin
        digit = diff[3:0] + RADIX4;
        cout  = 1'b1;
      end else begin
        digit = diff[3:0];
      end
    end else begin
      if (sum > {1'b0, BCD_MAX}) begin
        digit = sum[3:0] - RADIX4;
        cout  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_addsub_seq.sv
// ----------------------------------------------------------------------------
// | Module   : bcd_addsub_seq                                                |
// | Purpose  : Sequential packed-BCD adder/subtractor, one digit per clock,  |
// |            LSB first, with start/done handshake. Subtraction returns     |
// |            sign-magnitude; addition returns sum plus carry-out.          |
// | Ports    : clk, rst_n        clock, async active-low reset               |
// |            start, op         request (IDLE only), 0=add 1=sub            |
// |            x, y              packed BCD operands (4*DIGITS)              |
// |            busy, done        in-progress flag, one-cycle result pulse    |
// |            result, sign      BCD magnitude, negative flag (sub)          |
// |            carry_out         add overflow                                |
// |            invalid           a non-BCD digit was seen at accept          |
// | Revision : 1.0  initial release                                          |
// ----------------------------------------------------------------------------
`default_nettype none

module bcd_addsub_seq
  import bcd_addsub_seq_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                op,
  input  logic [4*DIGITS-1:0] x,
  input  logic [4*DIGITS-1:0] y,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] result,
  output logic                sign,
  output logic                carry_out,
  output logic                invalid
);

  localparam int              W        = 4 * DIGITS;
  localparam int              IW       = $clog2(DIGITS) + 1;
  localparam logic [IW-1:0]   LAST_IDX = IW'(DIGITS - 1);

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) bad = bad | digit_bad(v[4*i +: 4]);
    return bad;
  endfunction

  state_t        state, state_nx;
  logic          op_r;
  logic [W-1:0]  a_r, b_r, result_r;
  logic [IW-1:0] idx;
  logic          c_r, sign_r, invalid_r;
  logic [3:0]    a_dig, b_dig, alu_dig;
  logic          alu_cout;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_CALC;
      ST_CALC: if (idx == LAST_IDX) state_nx = ST_FIN;
      ST_FIN:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_CALC) || (state == ST_FIN);

  // --------------------------------------------- digit select and ALU
  always_comb begin
    a_dig = 4'd0;
    b_dig = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        a_dig = a_r[4*i +: 4];
        b_dig = b_r[4*i +: 4];
      end
    end
  end

  bcd_addsub_seq_digit_alu u_alu (
    .a     (a_dig),
    .b     (b_dig),
    .cin   (c_r),
    .op    (op_r),
    .digit (alu_dig),
    .cout  (alu_cout)
  );

  // -------------------------------------------- datapath and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r      <= OP_ADD;
      a_r       <= '0;
      b_r       <= '0;
      result_r  <= '0;
      idx       <= '0;
      c_r       <= 1'b0;
      sign_r    <= 1'b0;
      invalid_r <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      sign      <= 1'b0;
      carry_out <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_r      <= op;
            invalid_r <= has_bad_digit(x) | has_bad_digit(y);
            idx       <= '0;
            c_r       <= 1'b0;
            // BCD digit order matches binary order, so a plain vector
            // compare picks the larger operand; swapping keeps the final
            // borrow zero and the result a magnitude.
            if (op == OP_SUB && y > x) begin
              a_r    <= y;
              b_r    <= x;
              sign_r <= 1'b1;
            end else begin
              a_r    <= x;
              b_r    <= y;
              sign_r <= 1'b0;
            end
          end
        end
        ST_CALC: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) result_r[4*i +: 4] <= alu_dig;
          end
          c_r <= alu_cout;
          idx <= idx + IW'(1);
        end
        ST_FIN: begin
          done    <= 1'b1;
          invalid <= invalid_r;
          if (invalid_r) begin
            result    <= '0;
            sign      <= 1'b0;
            carry_out <= 1'b0;
          end else begin
            result    <= result_r;
            sign      <= sign_r;
            carry_out <= (op_r == OP_ADD) ? c_r : 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_addsub_seq.sv
// ----------------------------------------------------------------------------
// | Module   : tb_bcd_addsub_seq                                             |
// | Purpose  : Self-checking bench for bcd_addsub_seq (DIGITS=3): directed   |
// |            scenarios with literal expectations plus randomized traffic   |
// |            compared every cycle against an integer-arithmetic model.     |
// | Revision : 1.0  initial release                                          |
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bcd_addsub_seq;

  localparam int DIGITS = 3;
  localparam int W      = 4 * DIGITS;

  typedef struct packed {
    logic [W-1:0] res;
    logic         sign;
    logic         carry;
    logic         inv;
  } exp_t;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         op    = 1'b0;
  logic [W-1:0] x     = '0;
  logic [W-1:0] y     = '0;
  logic         busy, done, sign, carry_out, invalid;
  logic [W-1:0] result;

  int compared   = 0;
  int mismatched = 0;
  bit checking   = 1'b0;

  bcd_addsub_seq #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .x         (x),
    .y         (y),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .sign      (sign),
    .carry_out (carry_out),
    .invalid   (invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: decode operands to integers and apply decimal arithmetic.
  function automatic exp_t mdl(input bit o, input logic [W-1:0] a, input logic [W-1:0] b);
    int   av, bv, p, r;
    bit   bad;
    exp_t e;
    av = 0; bv = 0; p = 1; bad = 1'b0; e = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1'b1;
      av += int'(a[4*i +: 4]) * p;
      bv += int'(b[4*i +: 4]) * p;
      p  *= 10;
    end
    if (bad) begin
      e.inv = 1'b1;
      return e;
    end
    if (!o) begin
      r       = av + bv;
      e.carry = (r >= p);
      r       = r % p;
    end else begin
      r      = av - bv;
      e.sign = (r < 0);
      if (r < 0) r = -r;
    end
    for (int i = 0; i < DIGITS; i++) begin
      e.res[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return e;
  endfunction

  // Cycle model: an accepted request completes DIGITS+1 edges later;
  // requests are only accepted when nothing is outstanding.
  int   remain;
  bit   m_done;
  exp_t pend, held;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remain <= 0;
      m_done <= 1'b0;
      pend   <= '0;
      held   <= '0;
    end else begin
      m_done <= 1'b0;
      if (remain > 0) begin
        remain <= remain - 1;
        if (remain == 1) begin
          m_done <= 1'b1;
          held   <= pend;
        end
      end else if (start) begin
        pend   <= mdl(op, x, y);
        remain <= DIGITS + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("busy",      W'(busy),      W'(remain > 0));
      check("done",      W'(done),      W'(m_done));
      check("result",    result,        held.res);
      check("sign",      W'(sign),      W'(held.sign));
      check("carry_out", W'(carry_out), W'(held.carry));
      check("invalid",   W'(invalid),   W'(held.inv));
    end
  end

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    for (int i = 0; i < DIGITS; i++) begin
      if ($urandom_range(0, 24) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
      else                            v[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  // Issue one request and wait for done; optionally poke start mid-run.
  task automatic run_op(input bit o, input logic [W-1:0] xa, input logic [W-1:0] ya,
                        input bit poke, output int lat);
    @(negedge clk);
    start = 1'b1; op = o; x = xa; y = ya;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 2) begin
        x = 12'h888; y = 12'h111; op = ~o;   // must not disturb the running op
        if (poke) begin start = 1'b1; x = 12'h111; end
      end
      if (k == 3) start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
    check("latency", W'(lat), W'(DIGITS + 2));
  endtask

  int lat;
  int extra_done;

  initial begin
    // model pinned against hand-computed values
    check("mdl_add",   mdl(1'b0, 12'h123, 12'h456).res, 12'h579);
    check("mdl_sub_s", W'(mdl(1'b1, 12'h075, 12'h250).sign), W'(1));
    check("mdl_carry", W'(mdl(1'b0, 12'h999, 12'h001).carry), W'(1));

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checking = 1'b1;
    check("rst_busy",   W'(busy), '0);
    check("rst_result", result,   '0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(1'b0, 12'h123, 12'h456, 1'b0, lat);
    check("t1_result", result, 12'h579);
    check("t1_sign",   W'(sign), '0);
    check("t1_carry",  W'(carry_out), '0);
    check("t1_inv",    W'(invalid), '0);

    run_op(1'b0, 12'h999, 12'h001, 1'b0, lat);
    check("t2_result", result, 12'h000);
    check("t2_carry",  W'(carry_out), W'(1));
    run_op(1'b0, 12'h095, 12'h005, 1'b0, lat);
    check("t2_ripple", result, 12'h100);

    run_op(1'b1, 12'h250, 12'h075, 1'b0, lat);
    check("t3_result", result, 12'h175);
    check("t3_sign",   W'(sign), '0);
    run_op(1'b1, 12'h075, 12'h250, 1'b0, lat);
    check("t3n_result", result, 12'h175);
    check("t3n_sign",   W'(sign), W'(1));

    run_op(1'b1, 12'h400, 12'h400, 1'b1, lat);
    check("t4_result", result, 12'h000);
    check("t4_sign",   W'(sign), '0);
    extra_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    check("t4_no_queue", W'(extra_done), '0);
    check("t4_held",     result, 12'h000);

    run_op(1'b0, 12'h12A, 12'h001, 1'b0, lat);
    check("t5_inv",    W'(invalid), W'(1));
    check("t5_result", result, 12'h000);

    // reset in the middle of a calculation
    @(negedge clk);
    start = 1'b1; op = 1'b0; x = 12'h123; y = 12'h456;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy",   W'(busy), '0);
    check("t6_result", result,   '0);
    check("t6_done",   W'(done), '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 12'h123, 12'h456, 1'b0, lat);
    check("t6_after", result, 12'h579);

    // randomized traffic, including held start, operand churn and resets
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      rst_n = 1'b1;
      start = ($urandom_range(0, 2) == 0);
      op    = 1'($urandom_range(0, 1));
      x     = rand_bcd();
      y     = rand_bcd();
      if ($urandom_range(0, 149) == 0) begin
        #2 rst_n = 1'b0;
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
